// File: rtl/exe_divider.sv
// exe_divider: iterative 32-bit radix-2 restoring divider (div.w/mod.w/div.wu/mod.wu).
// Optional macro EXE_DIV_ZERO_FAST_EN: zero divisor completes in one cycle with q=all-ones, r=x.
module exe_divider (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_valid,
    output logic        div_ready,
    input  logic        div_signed,
    input  logic [31:0] div_x,
    input  logic [31:0] div_y,
    input  logic        div_flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] div_q,
    output logic [31:0] div_r
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      r_state;
    logic [31:0] r_x, r_y, r_rem, r_quo;
    logic [4:0]  r_cnt;
    logic        r_qs, r_rs;
    logic [31:0] w_ax, w_ay, w_rem, w_quo;
    logic [32:0] w_shift, w_sub;
    logic        w_bit;
    always_comb begin
        w_ax    = (div_signed && div_x[31]) ? -div_x : div_x;
        w_ay    = (div_signed && div_y[31]) ? -div_y : div_y;
        w_shift = {r_rem, r_x[31]};
        w_sub   = w_shift - {1'b0, r_y};
        w_bit   = !w_sub[32];
        w_rem   = w_bit ? w_sub[31:0] : w_shift[31:0];
        w_quo   = {r_quo[30:0], w_bit};
    end
    assign div_ready = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    // r_rem stays below the divisor, so 32 bits suffice between steps
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_qs    <= 1'b0;
            r_rs    <= 1'b0;
            div_q   <= '0;
            div_r   <= '0;
        end else if (div_flush) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: if (div_valid) begin
                    r_x     <= w_ax;
                    r_y     <= w_ay;
                    r_qs    <= div_signed & (div_x[31] ^ div_y[31]);
                    r_rs    <= div_signed & div_x[31];
                    r_rem   <= '0;
                    r_cnt   <= '0;
                    r_state <= CALC;
`ifdef EXE_DIV_ZERO_FAST_EN
                    if (div_y == '0) begin
                        r_state <= DONE;
                        div_q   <= '1;
                        div_r   <= div_x;
                    end
`endif
                end
                CALC: begin
                    r_x   <= r_x << 1;
                    r_rem <= w_rem;
                    r_quo <= w_quo;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= DONE;
                        div_q   <= r_qs ? -w_quo : w_quo;
                        div_r   <= r_rs ? -w_rem : w_rem;
                    end
                end
                DONE: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exe_divider.sv
// tb_exe_divider: directed vectors with hand-computed results for exe_divider.
module tb_exe_divider;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        div_valid = 1'b0;
    logic        div_ready;
    logic        div_signed = 1'b0;
    logic [31:0] div_x = '0;
    logic [31:0] div_y = '0;
    logic        div_flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] div_q, div_r;
    int          total = 0;
    int          bad = 0;
    int          lat;
    logic        ok;
    exe_divider dut (
        .clk(clk), .resetn(resetn), .div_valid(div_valid), .div_ready(div_ready),
        .div_signed(div_signed), .div_x(div_x), .div_y(div_y), .div_flush(div_flush),
        .out_valid(out_valid), .out_ready(out_ready), .div_q(div_q), .div_r(div_r)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask
    task automatic start(input logic s, input logic [31:0] x, input logic [31:0] y);
        div_signed = s;
        div_x      = x;
        div_y      = y;
        div_valid  = 1'b1;
        step();
        div_valid  = 1'b0;
        div_x      = 32'hDEADBEEF;
        div_y      = 32'h12345678;
    endtask
    task automatic wait_out(output int n);
        n = 1;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
    endtask
    task automatic consume(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_ready"}, {31'd0, div_ready}, 32'd1);
    endtask
    task automatic run(input string tag, input logic s, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] q, input logic [31:0] r);
        start(s, x, y);
        wait_out(lat);
        check({tag, "_lat"}, lat, 32'd33);
        check({tag, "_q"}, div_q, q);
        check({tag, "_r"}, div_r, r);
        consume(tag);
    endtask
    initial begin
        step();
        step();
        check("rst_ready", {31'd0, div_ready}, 32'd1);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_q", div_q, 32'd0);
        check("rst_r", div_r, 32'd0);
        resetn = 1'b1;
        step();
        // unsigned, then hold the result under backpressure
        start(1'b0, 32'd100, 32'd7);
        wait_out(lat);
        check("u100_7_lat", lat, 32'd33);
        check("u100_7_q", div_q, 32'd14);
        check("u100_7_r", div_r, 32'd2);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ok &= (div_q == 32'd14) && (div_r == 32'd2) && !div_ready && out_valid;
            step();
        end
        check("bp_hold", {31'd0, ok}, 32'd1);
        consume("bp");
        run("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        run("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
        run("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
        run("u_big", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        run("u_max1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0);
        // flush at t+10, restart at t+11
        start(1'b0, 32'd1000, 32'd3);
        ok = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ok |= out_valid;
            step();
        end
        div_flush = 1'b1;
        step();
        div_flush = 1'b0;
        check("fl_ready", {31'd0, div_ready}, 32'd1);
        check("fl_novalid", {31'd0, ok | out_valid}, 32'd0);
        run("fl_200_10", 1'b0, 32'd200, 32'd10, 32'd20, 32'd0);
        // flush together with a request blocks acceptance
        div_flush = 1'b1;
        start(1'b0, 32'd9, 32'd3);
        div_flush = 1'b0;
        check("fl_noacc", {31'd0, div_ready}, 32'd1);
        // reset at t+20
        start(1'b0, 32'd1000, 32'd3);
        for (int i = 0; i < 19; i++) step();
        resetn    = 1'b0;
        div_valid = 1'b1;
        div_x     = 32'd50;
        div_y     = 32'd5;
        step();
        check("mr_ready", {31'd0, div_ready}, 32'd1);
        check("mr_valid", {31'd0, out_valid}, 32'd0);
        check("mr_q", div_q, 32'd0);
        check("mr_r", div_r, 32'd0);
        step();
        resetn    = 1'b1;
        div_valid = 1'b0;
        step();
        check("mr_noacc", {31'd0, div_ready}, 32'd1);
        run("u_post", 1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF);
        // divide by zero
        start(1'b0, 32'd5, 32'd0);
        wait_out(lat);
`ifdef EXE_DIV_ZERO_FAST_EN
        check("dz_lat", lat, 32'd1);
        check("dz_q", div_q, 32'hFFFFFFFF);
        check("dz_r", div_r, 32'd5);
`else
        check("dz_lat", lat, 32'd33);
`endif
        consume("dz");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
